// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one FloatAdder among NREQ requesters.
// One operation in flight; hung adders are aborted after TIMEOUT wait cycles.
module fp_add_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      ReqValid,
  output logic [NREQ-1:0]      ReqReady,
  input  logic [32*NREQ-1:0]   ReqOp1,
  input  logic [32*NREQ-1:0]   ReqOp2,
  output logic [NREQ-1:0]      RspValid,
  input  logic [NREQ-1:0]      RspReady,
  output logic [31:0]          RspResult,
  output logic                 RspError,
  output logic [31:0]          AddOp1,
  output logic [31:0]          AddOp2,
  output logic                 AddInputValid,
  input  logic [31:0]          AddResult,
  input  logic                 AddResultValid,
  output logic                 Busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [PW:0]   NreqW   = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LastIdx = PW'(NREQ - 1);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StBlank, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     op1_q, op1_d, op2_q, op2_d;
  logic [31:0]     res_q, res_d;
  logic            err_q, err_d;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [PW:0]     cand_sum;
  logic [PW-1:0]   cand;
  logic [31:0]     req_op1 [NREQ];
  logic [31:0]     req_op2 [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_op1[i] = ReqOp1[32*i +: 32];
    assign req_op2[i] = ReqOp2[32*i +: 32];
  end

  // First requesting index at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (cand_sum >= NreqW) cand_sum = cand_sum - NreqW;
      cand = cand_sum[PW-1:0];
      if (!gnt_found && ReqValid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    res_d         = res_q;
    err_d         = err_q;
    ReqReady      = '0;
    RspValid      = '0;
    AddInputValid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          ReqReady = NREQ'(1) << gnt_idx;
          op1_d    = req_op1[gnt_idx];
          op2_d    = req_op2[gnt_idx];
          gnt_d    = gnt_idx;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        AddInputValid = 1'b1;
        state_d       = StBlank;
      end
      // The adder's ResultValid may still show the previous op's level here.
      StBlank: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (AddResultValid) begin
          res_d   = AddResult;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        RspValid = NREQ'(1) << gnt_q;
        if (RspReady[gnt_q]) begin
          rr_ptr_d = (gnt_q == LastIdx) ? '0 : gnt_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (Reset) ReqReady = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  assign AddOp1    = op1_q;
  assign AddOp2    = op2_q;
  assign RspResult = res_q;
  assign RspError  = err_q;
  assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: stub adder with configurable latency/stale/hang behaviour
// and a round-robin reference model computed from the grant rules.
module tb_fp_add_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic                Clock = 1'b0;
  logic                Reset = 1'b1;
  logic [NREQ-1:0]     ReqValid = '0;
  logic [NREQ-1:0]     ReqReady;
  logic [32*NREQ-1:0]  ReqOp1 = '0;
  logic [32*NREQ-1:0]  ReqOp2 = '0;
  logic [NREQ-1:0]     RspValid;
  logic [NREQ-1:0]     RspReady = '0;
  logic [31:0]         RspResult;
  logic                RspError;
  logic [31:0]         AddOp1, AddOp2;
  logic                AddInputValid;
  logic [31:0]         AddResult = '0;
  logic                AddResultValid = 1'b0;
  logic                Busy;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  // Stub adder: mode 0 normal, 1 never answers, 2 keeps the old valid level through BLANK.
  int          adder_mode = 0;
  int          adder_lat  = 1;
  int          lat_cnt    = 0;
  bit          pending    = 1'b0;
  bit          hold_stale = 1'b0;
  logic [31:0] stub_res   = '0;

  always #5 Clock = ~Clock;

  fp_add_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp1(ReqOp1), .ReqOp2(ReqOp2),
    .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult), .RspError(RspError),
    .AddOp1(AddOp1), .AddOp2(AddOp2), .AddInputValid(AddInputValid),
    .AddResult(AddResult), .AddResultValid(AddResultValid), .Busy(Busy)
  );

  // Not a float adder: known float pairs map to their true sums, anything else to a+b.
  function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h40A00000 && b == 32'hC0400000) return 32'h40000000;
    return a + b;
  endfunction

  always @(posedge Clock) begin
    if (AddInputValid) begin
      stub_res <= stub_sum(AddOp1, AddOp2);
      lat_cnt  <= adder_lat;
      pending  <= (adder_mode != 1);
      if (adder_mode == 2) hold_stale <= 1'b1;
      else AddResultValid <= 1'b0;
    end else begin
      if (hold_stale) begin
        hold_stale     <= 1'b0;
        AddResultValid <= 1'b0;
      end
      if (pending) begin
        if (lat_cnt <= 1) begin
          AddResultValid <= 1'b1;
          AddResult      <= stub_res;
          pending        <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  function automatic logic [NREQ-1:0] onehot(input int g);
    return NREQ'(1) << g;
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] mask, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] op1_of(input int i);
    return ReqOp1[32*i +: 32];
  endfunction

  function automatic logic [31:0] op2_of(input int i);
    return ReqOp2[32*i +: 32];
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    ReqOp1[32*i +: 32] = a;
    ReqOp2[32*i +: 32] = b;
  endtask

  task automatic random_ops();
    for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1; ReqValid = '0; RspReady = '0;
    tick(); tick();
    Reset = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; ReqValid = '1; RspReady = '0;
    tick(); tick();
    checks++;
    if (ReqReady !== '0) begin
      errors++; $display("FAIL reset_reqready got=%b exp=0", ReqReady);
    end
    checks++;
    if ({RspValid, RspError, RspResult, AddOp1, AddOp2, AddInputValid, Busy} !== '0) begin
      errors++;
      $display("FAIL reset_state got RspValid=%b RspError=%b RspResult=%h AddOp1=%h AddOp2=%h AIV=%b Busy=%b exp all 0",
               RspValid, RspError, RspResult, AddOp1, AddOp2, AddInputValid, Busy);
    end
    Reset = 1'b0; ReqValid = '0; model_ptr = 0;
    tick();
  endtask

  task automatic test_basic();
    int lat, pulses;
    random_ops();
    set_ops(0, 32'h3F800000, 32'h40000000);
    adder_mode = 0; adder_lat = 1; RspReady = '0;
    ReqValid = 4'b0001;
    #1;
    checks++;
    if (ReqReady !== 4'b0001) begin
      errors++; $display("FAIL basic_grant got=%b exp=0001", ReqReady);
    end
    tick();
    ReqValid = '0;
    checks++;
    if (AddInputValid !== 1'b1 || AddOp1 !== 32'h3F800000 || AddOp2 !== 32'h40000000) begin
      errors++;
      $display("FAIL basic_issue got AIV=%b op1=%h op2=%h exp 1 3f800000 40000000",
               AddInputValid, AddOp1, AddOp2);
    end
    lat = 1; pulses = 1;
    while (RspValid === '0 && lat < 30) begin
      tick(); lat++;
      if (AddInputValid === 1'b1) pulses++;
    end
    checks++;
    if (RspValid !== 4'b0001 || RspResult !== 32'h40400000 || RspError !== 1'b0) begin
      errors++;
      $display("FAIL basic_rsp got valid=%b result=%h err=%b exp 0001 40400000 0",
               RspValid, RspResult, RspError);
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL basic_latency got=%0d exp=4", lat);
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL basic_issue_pulses got=%0d exp=1", pulses);
    end
    RspReady = 4'b0001;
    tick();
    RspReady = '0;
    model_ptr = 1;
    checks++;
    if (RspValid !== '0 || Busy !== 1'b0) begin
      errors++; $display("FAIL basic_done got valid=%b busy=%b exp 0 0", RspValid, Busy);
    end
  endtask

  task automatic test_round_robin();
    int g, w;
    pulse_reset();
    random_ops();
    set_ops(2, 32'h40A00000, 32'hC0400000);
    adder_mode = 0; adder_lat = 2;
    ReqValid = '1; RspReady = '1;
    #1;
    for (int n = 0; n < 5; n++) begin
      g = model_grant(ReqValid, model_ptr);
      w = 0;
      while (ReqReady === '0 && w < 10) begin tick(); w++; end
      checks++;
      if (ReqReady !== onehot(g) || w != 0) begin
        errors++; $display("FAIL rr_grant%0d got=%b exp=%b waited=%0d", n, ReqReady, onehot(g), w);
      end
      tick();
      w = 0;
      while (RspValid === '0 && w < 30) begin tick(); w++; end
      checks++;
      if (RspValid !== onehot(g) || RspResult !== stub_sum(op1_of(g), op2_of(g)) ||
          RspError !== 1'b0) begin
        errors++;
        $display("FAIL rr_rsp%0d got valid=%b result=%h err=%b exp %b %h 0", n, RspValid,
                 RspResult, RspError, onehot(g), stub_sum(op1_of(g), op2_of(g)));
      end
      model_ptr = (g + 1) % NREQ;
      tick();
    end
    ReqValid = '0; RspReady = '0;
    #1;
  endtask

  task automatic test_rsp_stall();
    int g, w;
    random_ops();
    ReqValid = '1; RspReady = '0;
    #1;
    g = model_grant(ReqValid, model_ptr);
    RspReady = ~onehot(g);
    checks++;
    if (ReqReady !== onehot(g)) begin
      errors++; $display("FAIL stall_grant got=%b exp=%b", ReqReady, onehot(g));
    end
    tick();
    w = 0;
    while (RspValid === '0 && w < 30) begin tick(); w++; end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (RspValid !== onehot(g) || RspResult !== stub_sum(op1_of(g), op2_of(g)) ||
          AddInputValid !== 1'b0 || ReqReady !== '0) begin
        errors++;
        $display("FAIL stall_hold%0d got valid=%b result=%h aiv=%b rdy=%b exp %b %h 0 0", k,
                 RspValid, RspResult, AddInputValid, ReqReady, onehot(g),
                 stub_sum(op1_of(g), op2_of(g)));
      end
      tick();
    end
    RspReady = onehot(g); ReqValid = '0;
    tick();
    RspReady = '0;
    model_ptr = (g + 1) % NREQ;
    checks++;
    if (RspValid !== '0 || Busy !== 1'b0) begin
      errors++; $display("FAIL stall_release got valid=%b busy=%b exp 0 0", RspValid, Busy);
    end
  endtask

  task automatic test_timeout();
    int g, n, g2;
    logic [NREQ-1:0] mask;
    random_ops();
    adder_mode = 1;
    g = model_ptr;
    ReqValid = onehot(g); RspReady = '0;
    #1;
    tick();
    ReqValid = '0;
    n = 0;
    while (RspValid === '0 && n < 200) begin tick(); n++; end
    checks++;
    if (n != TIMEOUT + 2) begin
      errors++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TIMEOUT + 2);
    end
    checks++;
    if (RspValid !== onehot(g) || RspError !== 1'b1 || RspResult !== 32'h0) begin
      errors++;
      $display("FAIL timeout_rsp got valid=%b err=%b result=%h exp %b 1 0", RspValid, RspError,
               RspResult, onehot(g));
    end
    RspReady = onehot(g);
    tick();
    RspReady = '0;
    model_ptr = (g + 1) % NREQ;
    mask = onehot(g) | onehot((g + 2) % NREQ);
    ReqValid = mask;
    #1;
    g2 = model_grant(mask, model_ptr);
    checks++;
    if (ReqReady !== onehot(g2)) begin
      errors++; $display("FAIL timeout_ptr_advance got=%b exp=%b", ReqReady, onehot(g2));
    end
    ReqValid = '0;
    #1;
    adder_mode = 0;
  endtask

  task automatic test_stale();
    int g, n;
    logic [31:0] old_sum;
    random_ops();
    adder_mode = 0; adder_lat = 1; RspReady = '0;
    g = model_ptr;
    ReqValid = onehot(g);
    #1;
    tick();
    ReqValid = '0;
    n = 0;
    while (RspValid === '0 && n < 30) begin tick(); n++; end
    old_sum = stub_sum(op1_of(g), op2_of(g));
    checks++;
    if (RspValid !== onehot(g) || RspResult !== old_sum) begin
      errors++;
      $display("FAIL stale_first got valid=%b result=%h exp %b %h", RspValid, RspResult,
               onehot(g), old_sum);
    end
    RspReady = onehot(g);
    tick();
    RspReady = '0;
    model_ptr = (g + 1) % NREQ;
    // Second op: the adder's valid level from the first op lingers through BLANK.
    g = model_ptr;
    set_ops(g, $urandom, $urandom);
    if (stub_sum(op1_of(g), op2_of(g)) == old_sum) set_ops(g, op1_of(g), op2_of(g) + 1);
    adder_mode = 2; adder_lat = 3;
    ReqValid = onehot(g);
    #1;
    tick();
    ReqValid = '0;
    n = 1;
    while (RspValid === '0 && n < 30) begin tick(); n++; end
    checks++;
    if (RspValid !== onehot(g) || RspResult !== stub_sum(op1_of(g), op2_of(g))) begin
      errors++;
      $display("FAIL stale_capture got valid=%b result=%h exp %b %h", RspValid, RspResult,
               onehot(g), stub_sum(op1_of(g), op2_of(g)));
    end
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL stale_latency got=%0d exp=6", n);
    end
    RspReady = onehot(g);
    tick();
    RspReady = '0;
    model_ptr = (g + 1) % NREQ;
    adder_mode = 0;
  endtask

  task automatic test_reset_mid();
    int g;
    random_ops();
    adder_mode = 0; adder_lat = 10; RspReady = '0;
    g = model_ptr;
    ReqValid = onehot(g);
    #1;
    tick();
    ReqValid = '0;
    tick(); tick();
    checks++;
    if (Busy !== 1'b1) begin
      errors++; $display("FAIL midreset_busy got=%b exp=1", Busy);
    end
    Reset = 1'b1;
    tick();
    checks++;
    if ({ReqReady, RspValid, RspError, RspResult, AddOp1, AddOp2, AddInputValid, Busy} !== '0) begin
      errors++;
      $display("FAIL midreset_state got rdy=%b valid=%b err=%b res=%h op1=%h op2=%h aiv=%b busy=%b exp all 0",
               ReqReady, RspValid, RspError, RspResult, AddOp1, AddOp2, AddInputValid, Busy);
    end
    Reset = 1'b0;
    model_ptr = 0;
    RspReady = '1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (RspValid !== '0 || Busy !== 1'b0) begin
        errors++; $display("FAIL midreset_quiet%0d got valid=%b busy=%b exp 0 0", k, RspValid, Busy);
      end
    end
    RspReady = '0;
  endtask

  task automatic test_random();
    int g, w, d;
    logic [NREQ-1:0] mask;
    adder_mode = 0;
    for (int n = 0; n < 30; n++) begin
      random_ops();
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      adder_lat = $urandom_range(1, 6);
      d = $urandom_range(0, 3);
      RspReady = '0;
      ReqValid = mask;
      #1;
      g = model_grant(mask, model_ptr);
      checks++;
      if (ReqReady !== onehot(g)) begin
        errors++; $display("FAIL rand_grant%0d got=%b exp=%b", n, ReqReady, onehot(g));
      end
      tick();
      ReqValid = '0;
      checks++;
      if (AddInputValid !== 1'b1 || AddOp1 !== op1_of(g) || AddOp2 !== op2_of(g)) begin
        errors++;
        $display("FAIL rand_issue%0d got aiv=%b op1=%h op2=%h exp 1 %h %h", n, AddInputValid,
                 AddOp1, AddOp2, op1_of(g), op2_of(g));
      end
      w = 0;
      while (RspValid === '0 && w < 50) begin tick(); w++; end
      checks++;
      if (RspValid !== onehot(g) || RspResult !== stub_sum(op1_of(g), op2_of(g)) ||
          RspError !== 1'b0) begin
        errors++;
        $display("FAIL rand_rsp%0d got valid=%b result=%h err=%b exp %b %h 0", n, RspValid,
                 RspResult, RspError, onehot(g), stub_sum(op1_of(g), op2_of(g)));
      end
      for (int k = 0; k < d; k++) begin
        RspReady = NREQ'($urandom) & ~onehot(g);
        tick();
      end
      RspReady = onehot(g);
      tick();
      RspReady = '0;
      model_ptr = (g + 1) % NREQ;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_rsp_stall();
    test_timeout();
    test_stale();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
